// File: rtl/rf_pkg.sv
// Shared register-file constants and writeback source indices.
// Also holds the modulo helper used by the round-robin arbiter.
package rf_pkg;

  localparam int XLEN   = 32;
  localparam int ADDR_W = 5;
  localparam int IDX_W  = 3;

  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

  localparam int SRC_LOAD = 0;
  localparam int SRC_LUI  = 1;
  localparam int SRC_JUMP = 2;
  localparam int SRC_ALU  = 3;

  // Wraps v into 0..n-1 for v < 2n, so non-power-of-two source counts skip unused indices.
  function automatic int wrap_idx(input int v, input int n);
    return (v >= n) ? (v - n) : v;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, modulo NUM_REQ.
// Produces a one-hot grant, its binary index and an any-grant flag.
module rr_arbiter
  import rf_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any
);

  // NOTE: every output gets a default before the search loop so no latch is inferred.
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!o_any && i_req[i] && (wrap_idx(int'(i_ptr) + k, NUM_REQ) == i)) begin
          o_any    = 1'b1;
          o_gnt[i] = 1'b1;
          o_idx    = IDX_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between writeback sources.
// Grants are combinational; the write command is registered with one cycle of latency.
module regfile_wb_arbiter
  import rf_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        i_req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] i_req_addr,
  input  logic [NUM_REQ*XLEN-1:0]   i_req_data,
  output logic [NUM_REQ-1:0]        o_req_ready,
  input  logic                      i_wr_stall,
  output logic                      o_wr_en,
  output logic [ADDR_W-1:0]         o_wr_addr,
  output logic [XLEN-1:0]           o_wr_data,
  output logic [IDX_W-1:0]          o_grant_id
);

  logic [IDX_W-1:0]   r_rr_ptr;
  logic               r_wr_en;
  logic [ADDR_W-1:0]  r_wr_addr;
  logic [XLEN-1:0]    r_wr_data;
  logic [IDX_W-1:0]   r_grant_id;

  logic [NUM_REQ-1:0] w_req_masked;
  logic [NUM_REQ-1:0] w_gnt;
  logic [IDX_W-1:0]   w_idx;
  logic               w_any;
  logic [ADDR_W-1:0]  w_sel_addr;
  logic [XLEN-1:0]    w_sel_data;

  // Reset and stall both suppress grants, so requests seen during reset are simply dropped.
  assign w_req_masked = i_req_valid & {NUM_REQ{~rst & ~i_wr_stall}};

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
    .i_req (w_req_masked),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  always_comb begin
    w_sel_addr = '0;
    w_sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) begin
        w_sel_addr = i_req_addr[i*ADDR_W +: ADDR_W];
        w_sel_data = i_req_data[i*XLEN +: XLEN];
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr   <= '0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_grant_id <= '0;
    end else if (w_any) begin
      r_rr_ptr   <= IDX_W'(wrap_idx(int'(w_idx) + 1, NUM_REQ));
      r_wr_en    <= (w_sel_addr != ADDR_W'(REG_ZERO));
      r_wr_addr  <= w_sel_addr;
      r_wr_data  <= w_sel_data;
      r_grant_id <= w_idx;
    end else begin
      r_wr_en    <= 1'b0;
    end
  end

  assign o_req_ready = w_gnt;
  assign o_wr_en     = r_wr_en;
  assign o_wr_addr   = r_wr_addr;
  assign o_wr_data   = r_wr_data;
  assign o_grant_id  = r_grant_id;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed test-plan steps followed by
// randomized traffic, all compared against a behavioural round-robin model.
module tb_regfile_wb_arbiter;

  localparam int N  = 4;
  localparam int AW = 5;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            wr_stall;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;
  logic [2:0]      grant_id;

  regfile_wb_arbiter #(.NUM_REQ(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_req_valid (req_valid),
    .i_req_addr  (req_addr),
    .i_req_data  (req_data),
    .o_req_ready (req_ready),
    .i_wr_stall  (wr_stall),
    .o_wr_en     (wr_en),
    .o_wr_addr   (wr_addr),
    .o_wr_data   (wr_data),
    .o_grant_id  (grant_id)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Source-side view of the requests
  logic          src_valid [N];
  logic [AW-1:0] src_addr  [N];
  logic [DW-1:0] src_data  [N];

  // Reference model state
  int          m_ptr;
  logic        m_en;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  int          m_gid;
  logic        m_any;
  int          m_g;
  logic [N-1:0] last_ready;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_src(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    src_valid[i] = v;
    src_addr[i]  = a;
    src_data[i]  = d;
  endtask

  task automatic clear_all();
    for (int i = 0; i < N; i++) set_src(i, 1'b0, '0, '0);
  endtask

  // Called just after a falling edge: drive, check ready, predict, clock, check outputs.
  task automatic run_cycle();
    logic [N-1:0] exp_ready;
    for (int i = 0; i < N; i++) begin
      req_valid[i]           = src_valid[i];
      req_addr[i*AW +: AW]   = src_addr[i];
      req_data[i*DW +: DW]   = src_data[i];
    end
    #1;
    exp_ready = '0;
    m_any = 1'b0;
    m_g   = 0;
    if (!rst && !wr_stall) begin
      for (int k = 0; k < N; k++) begin
        int s;
        s = (m_ptr + k) % N;
        if (!m_any && src_valid[s]) begin
          m_any = 1'b1;
          m_g   = s;
        end
      end
    end
    if (m_any) exp_ready[m_g] = 1'b1;
    last_ready = req_ready;
    chk("req_ready", 64'(req_ready), 64'(exp_ready));

    if (rst) begin
      m_ptr = 0; m_en = 1'b0; m_addr = '0; m_data = '0; m_gid = 0;
    end else if (m_any) begin
      m_ptr  = (m_g + 1) % N;
      m_en   = (src_addr[m_g] != 0);
      m_addr = src_addr[m_g];
      m_data = src_data[m_g];
      m_gid  = m_g;
    end else begin
      m_en = 1'b0;
    end

    @(posedge clk);
    #1;
    chk("wr_en",    64'(wr_en),    64'(m_en));
    chk("wr_addr",  64'(wr_addr),  64'(m_addr));
    chk("wr_data",  64'(wr_data),  64'(m_data));
    chk("grant_id", 64'(grant_id), 64'(m_gid));
    @(negedge clk);
  endtask

  initial begin
    rst       = 1'b1;
    wr_stall  = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    m_ptr = 0; m_en = 1'b0; m_addr = '0; m_data = '0; m_gid = 0;
    for (int i = 0; i < N; i++) set_src(i, 1'b1, AW'(i + 10), DW'(32'hA000 + i));
    @(negedge clk);

    // Reset held two cycles with every source valid
    run_cycle();
    chk("rst_ready0", 64'(last_ready), 64'd0);
    chk("rst_wr_en0", 64'(wr_en), 64'd0);
    run_cycle();
    chk("rst_ready1", 64'(last_ready), 64'd0);
    chk("rst_wr_en1", 64'(wr_en), 64'd0);
    rst = 1'b0;

    // Fairness: all valid continuously -> 0,1,2,3,0
    for (int n = 0; n < 5; n++) begin
      run_cycle();
      chk("fair_gid", 64'(grant_id), 64'(n % N));
      chk("fair_en",  64'(wr_en), 64'd1);
      chk("fair_addr", 64'(wr_addr), 64'((n % N) + 10));
    end
    clear_all();

    // Single source 1
    set_src(1, 1'b1, 5'd5, 32'h0000_1234);
    run_cycle();
    chk("single_ready", 64'(last_ready), 64'b0010);
    chk("single_en",    64'(wr_en), 64'd1);
    chk("single_addr",  64'(wr_addr), 64'd5);
    chk("single_data",  64'(wr_data), 64'h1234);
    chk("single_gid",   64'(grant_id), 64'd1);
    clear_all();

    // x0 write from source 3: handshaken but not written
    set_src(3, 1'b1, 5'd0, 32'hDEAD_BEEF);
    run_cycle();
    chk("x0_ready", 64'(last_ready), 64'b1000);
    chk("x0_en",    64'(wr_en), 64'd0);
    clear_all();

    // Stall with sources 0 and 2 pending; pointer is back at 0
    set_src(0, 1'b1, 5'd7, 32'h0000_0777);
    set_src(2, 1'b1, 5'd9, 32'h0000_0999);
    wr_stall = 1'b1;
    for (int n = 0; n < 3; n++) begin
      run_cycle();
      chk("stall_ready", 64'(last_ready), 64'd0);
      chk("stall_en",    64'(wr_en), 64'd0);
    end
    wr_stall = 1'b0;
    run_cycle();
    chk("stall_first", 64'(grant_id), 64'd0);
    src_valid[0] = 1'b0;
    run_cycle();
    chk("stall_second", 64'(grant_id), 64'd2);
    chk("stall_second_data", 64'(wr_data), 64'h999);
    clear_all();

    // Withdraw: source 2 presents under stall, then drops before a grant
    set_src(2, 1'b1, 5'd12, 32'h0000_0C0C);
    wr_stall = 1'b1;
    run_cycle();
    wr_stall = 1'b0;
    src_valid[2] = 1'b0;
    run_cycle();
    chk("withdraw_en", 64'(wr_en), 64'd0);

    // Mid-reset: source 1 pending under stall, reset pulsed, then re-presented
    set_src(1, 1'b1, 5'd20, 32'h0000_2020);
    wr_stall = 1'b1;
    run_cycle();
    wr_stall = 1'b0;
    rst = 1'b1;
    run_cycle();
    chk("midrst_ready", 64'(last_ready), 64'd0);
    rst = 1'b0;
    src_valid[1] = 1'b0;
    run_cycle();
    chk("midrst_dropped", 64'(wr_en), 64'd0);
    src_valid[1] = 1'b1;
    run_cycle();
    chk("midrst_repres_en",  64'(wr_en), 64'd1);
    chk("midrst_repres_gid", 64'(grant_id), 64'd1);
    clear_all();

    // Randomized traffic with stalls, withdrawals and occasional resets
    for (int n = 0; n < 400; n++) begin
      wr_stall = ($urandom_range(0, 4) == 0);
      rst      = ($urandom_range(0, 49) == 0);
      run_cycle();
      for (int i = 0; i < N; i++) begin
        if (src_valid[i]) begin
          if ((m_any && m_g == i) || $urandom_range(0, 9) == 0) src_valid[i] = 1'b0;
        end else if ($urandom_range(0, 9) < 4) begin
          set_src(i, 1'b1, AW'($urandom_range(0, 31)), $urandom);
        end
      end
    end
    rst = 1'b0;
    wr_stall = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port between several writeback sources: load data, LUI immediate, jump return address and ALU result.
- Each source uses a valid/ready handshake. The arbiter picks one source per cycle by round-robin and drives a registered write command (en/addr/data) into the register file.
- Sits between the execute/memory stages and the register file write inputs.

Parameters:
- NUM_REQ, 4, number of requesting writeback sources (2..8).
- XLEN, 32, data width of a register write.
- ADDR_W, 5, register address width (32 registers).

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  per-source write request.
- req_addr  input  NUM_REQ*ADDR_W  packed destination register numbers; source i uses bits [i*ADDR_W +: ADDR_W].
- req_data  input  NUM_REQ*XLEN  packed write data; source i uses bits [i*XLEN +: XLEN].
- req_ready  output  NUM_REQ  one-hot grant (combinational).
- wr_stall  input  1  register file cannot accept a write this cycle.
- wr_en  output  1  registered write enable to the register file.
- wr_addr  output  ADDR_W  registered write address.
- wr_data  output  XLEN  registered write data.
- grant_id  output  3  registered index of the source that produced the current wr_en.

Behaviour:
- Reset (rst high at a clk edge):
  - rr_ptr=0, wr_en=0, wr_addr=0, wr_data=0, grant_id=0.
  - req_ready=0 during every cycle in which rst is high.
- Handshake:
  - A transfer occurs on a cycle where req_valid[i]&&req_ready[i].
  - A source must hold valid, addr and data stable until that cycle.
  - Deasserting valid before the grant is allowed (request withdrawn, nothing is written).
- Arbitration (combinational):
  - If wr_stall=1 or no valid request, req_ready=0.
  - Otherwise exactly one bit of req_ready is set: the first valid source found scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
- Pointer update:
  - On a transfer from source i, rr_ptr <= (i+1) mod NUM_REQ.
  - With no transfer, rr_ptr holds.
  - The granted source therefore has lowest priority next cycle, and any continuously valid source waits at most NUM_REQ-1 grants.
- Output stage (1-cycle latency):
  - On a transfer from source i at edge N: wr_addr/wr_data/grant_id capture source i's addr, data and index, and wr_en=1, all visible after edge N.
  - wr_en=1 only if the granted addr is nonzero. Writes to x0 are handshaken and consume the grant slot, but wr_en=0 for them.
  - With no transfer, wr_en <= 0; wr_addr, wr_data and grant_id hold their last values.
- wr_stall:
  - Blocks new grants in the same cycle.
  - Does not cancel a write already registered on the outputs; the register file samples wr_en on the edge after the grant.
- Back-to-back: a new grant is possible every cycle, giving a throughput of 1 write/cycle.
- Simultaneous requests to the same rd from different sources are serialised in grant order, so the later grant wins in the register file.
- Reset mid-operation: any pending, ungranted requests are dropped by the arbiter (no state is kept for them). Sources must re-present their requests after rst falls.
- NUM_REQ not a power of two: the modulo wrap must skip the nonexistent indices.

Decomposition:
- Shared package `rf_pkg`:
  - XLEN and ADDR_W constants.
  - REG_ZERO = 5'd0.
  - Source index localparams: SRC_LOAD=0, SRC_LUI=1, SRC_JUMP=2, SRC_ALU=3.
- Sub-module `rr_arbiter` (NUM_REQ): combinational round-robin pick from req and ptr. Produces a one-hot grant and a binary index, and is reusable for the memory port.

Test Plan:
- Reset: assert rst 2 cycles with all sources valid -> req_ready=0 and wr_en=0 throughout. After release, first grant goes to source 0.
- Single source: source 1 valid with addr=5, data=0x0000_1234 -> req_ready=4'b0010 that cycle. Next cycle wr_en=1, wr_addr=5, wr_data=0x1234, grant_id=1.
- Fairness: all 4 sources valid continuously, each with a distinct addr -> grants go 0,1,2,3,0,...; wr_en=1 on 4 consecutive cycles.
- x0 write: source 3 valid with addr=0, data=0xDEAD_BEEF -> req_ready[3]=1, next cycle wr_en=0, and rr_ptr advances to 0.
- Stall: sources 0 and 2 valid, wr_stall=1 for 3 cycles -> no grants and wr_en=0. When the stall drops, source 0 is granted, then source 2 the following cycle.
- Withdraw and mid-reset: source 2 drops valid before its grant -> no write from source 2. rst pulsed while source 1 is pending -> source 1 is not written until it re-presents after reset.
